// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: r = a - b - borrow_in, one bit per clock, LSB first.
// start/busy/done handshake; results and flags update only on completion.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             brw;

    logic             diff;
    logic             brw_nxt;
    logic             last;
    logic [WIDTH-1:0] res;

    // a_sh/b_sh shift right, so bit 0 is always the bit being processed
    always_comb begin
        diff    = a_sh[0] ^ b_sh[0] ^ brw;
        brw_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
        last    = (cnt == CW'(WIDTH - 1));
        res     = {diff, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            r          <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= borrow_in;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    acc  <= res;
                    brw  <= brw_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        // on the last bit a_sh[0]/b_sh[0] hold the operand MSBs
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r          <= res;
                        borrow_out <= brw_nxt;
                        zero       <= (res == '0);
                        overflow   <= (a_sh[0] != b_sh[0]) && (diff != a_sh[0]);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
